// File: rtl/dso_capture_mc.sv
// Multi-channel DSO trigger/capture engine (ad_clk domain).
// Decimates the ADC streams, keeps a pre-trigger window in a circular buffer,
// finds a hysteresis edge trigger and hands one frame at a time to the reader.
module dso_capture_mc #(
  parameter int NCH     = 2,
  parameter int DW      = 8,
  parameter int AW      = 11,
  parameter int DECI_W  = 10,
  parameter int AUTO_TO = 1_000_000
) (
  input  logic              ad_clk,
  input  logic              sys_rst,
  input  logic [NCH*DW-1:0] ad_data,
  input  logic              ad_valid,
  input  logic [DECI_W-1:0] deci_rate,
  input  logic [3:0]        trig_src,
  input  logic [DW-1:0]     trig_level,
  input  logic [DW-1:0]     trig_hyst,
  input  logic              trig_edge,
  input  logic [1:0]        trig_mode,
  input  logic              wave_run,
  input  logic              arm,
  input  logic [AW-1:0]     pre_depth,
  input  logic              rd_done,
  output logic              buf_wr,
  output logic [AW-1:0]     buf_wr_addr,
  output logic [NCH*DW-1:0] buf_wr_data,
  output logic              frame_ready,
  output logic [AW-1:0]     trig_addr,
  output logic              trig_auto
);

  localparam int DEPTH = 2 ** AW;
  localparam int TOW   = $clog2(AUTO_TO + 1);
  localparam logic [AW-1:0] PRE_MAX = AW'(DEPTH - 2);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     wr_ptr, pre_lat, pre_cnt, post_cnt, post_last;
  logic [DECI_W-1:0] deci_cnt, deci_lat, deci_eff;
  logic [TOW-1:0]    to_cnt;
  logic              hyst_flag;
  logic [DW-1:0]     trig_sample, thr_lo, thr_hi;
  logic [DW:0]       sum_hi;
  logic              capturing, keep, set_cond, hit_cond, fire, to_hit, take;
  logic              enter_pre, single_mode, auto_mode;

  // Select the trigger channel; out-of-range selects fall back to channel 0.
  always_comb begin
    trig_sample = ad_data[DW-1:0];
    for (int unsigned k = 1; k < NCH; k++)
      if (trig_src == 4'(k)) trig_sample = ad_data[k*DW +: DW];
  end

  // Hysteresis thresholds, saturated at 0 and full scale.
  always_comb begin
    thr_lo = (trig_level > trig_hyst) ? trig_level - trig_hyst : '0;
    sum_hi = {1'b0, trig_level} + {1'b0, trig_hyst};
    thr_hi = sum_hi[DW] ? '1 : sum_hi[DW-1:0];
  end

  // Next-state decode plus the per-cycle capture/trigger qualifiers.
  always_comb begin
    state_nx    = state;
    single_mode = (trig_mode == 2'b10);
    auto_mode   = (trig_mode == 2'b00);
    deci_eff    = (deci_rate == '0) ? DECI_W'(1) : deci_rate;
    post_last   = PRE_MAX - pre_lat;
    // arm or a wave_run drop pre-empts any write in the same cycle
    capturing   = !arm && wave_run &&
                  ((state == S_PRE && pre_lat != '0) || state == S_ARMED || state == S_POST);
    keep        = capturing && ad_valid && (deci_cnt == '0);
    if (trig_edge) begin
      set_cond = trig_sample < thr_lo;
      hit_cond = trig_sample >= trig_level;
    end else begin
      set_cond = trig_sample > thr_hi;
      hit_cond = trig_sample <= trig_level;
    end
    fire   = keep && (state == S_ARMED) && hyst_flag && hit_cond;
    to_hit = (to_cnt == TOW'(AUTO_TO));
    take   = keep && (state == S_ARMED) && (fire || (auto_mode && to_hit));
    case (state)
      S_IDLE:  if (wave_run && !single_mode) state_nx = S_PRE;
      S_PRE:   if (!wave_run) state_nx = S_IDLE;
               else if (pre_lat == '0) state_nx = S_ARMED;
               else if (keep && pre_cnt == pre_lat - AW'(1)) state_nx = S_ARMED;
      S_ARMED: if (!wave_run) state_nx = S_IDLE;
               else if (take) state_nx = S_POST;
      S_POST:  if (!wave_run) state_nx = S_IDLE;
               else if (keep && post_cnt == post_last) state_nx = S_DONE;
      S_DONE:  if (rd_done) state_nx = single_mode ? S_IDLE : S_PRE;
      default: state_nx = S_IDLE;
    endcase
    if (arm) state_nx = S_PRE;
    enter_pre = arm || (state != S_PRE && state_nx == S_PRE);
  end

  // State register.
  always_ff @(posedge ad_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Decimation, write pointer, phase counters and auto timeout.
  always_ff @(posedge ad_clk) begin
    if (sys_rst) begin
      deci_cnt <= '0;
      deci_lat <= DECI_W'(1);
      wr_ptr   <= '0;
      pre_lat  <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (enter_pre) begin
        deci_cnt <= '0;
        deci_lat <= deci_eff;
        pre_lat  <= (pre_depth > PRE_MAX) ? PRE_MAX : pre_depth;
        pre_cnt  <= '0;
        post_cnt <= '0;
      end else if (capturing && ad_valid) begin
        // keep happens at count 0; the new rate is picked up only on wrap
        if (deci_cnt >= deci_lat - DECI_W'(1)) begin
          deci_cnt <= '0;
          deci_lat <= deci_eff;
        end else begin
          deci_cnt <= deci_cnt + DECI_W'(1);
        end
        if (keep) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (state == S_PRE)  pre_cnt  <= pre_cnt + AW'(1);
          if (state == S_POST) post_cnt <= post_cnt + AW'(1);
        end
      end
      if (state != S_ARMED) to_cnt <= '0;
      else if (!to_hit)     to_cnt <= to_cnt + TOW'(1);
    end
  end

  // Hysteresis arming flag, evaluated on kept trigger-channel samples.
  always_ff @(posedge ad_clk) begin
    if (sys_rst || enter_pre) begin
      hyst_flag <= 1'b0;
    end else if (keep && (state == S_PRE || state == S_ARMED)) begin
      if (fire)          hyst_flag <= 1'b0;
      else if (set_cond) hyst_flag <= 1'b1;
    end
  end

  // Registered buffer write port and frame status outputs.
  always_ff @(posedge ad_clk) begin
    if (sys_rst) begin
      buf_wr      <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      frame_ready <= 1'b0;
      trig_addr   <= '0;
      trig_auto   <= 1'b0;
    end else begin
      buf_wr <= keep;
      if (keep) begin
        buf_wr_addr <= wr_ptr;
        buf_wr_data <= ad_data;
      end
      frame_ready <= (state_nx == S_DONE);
      if (arm) begin
        trig_auto <= 1'b0;
      end else if (take) begin
        trig_addr <= wr_ptr;
        trig_auto <= !fire;
      end
    end
  end

endmodule
